pat_key_ctrl: RTL and testbench

- Downstream consumer of the switch glitch filters.
- Takes three debounced, active-low, single-cycle key pulses: next, prev and pause.
- Maintains the display pattern index, with manual stepping, wrap-around, a key lockout window and an auto-run mode that advances the pattern on a fixed dwell time.
- Feeds the pattern index and a change strobe to the pattern generator.

---
 rtl/pat_key_ctrl.sv | 148 ++++++++++++++
 tb/tb_pat_key_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pat_key_ctrl.sv
// Pattern index controller: debounced next/prev/pause key pulses, wrap-around
// stepping, post-event key lockout and a timed auto-run mode.
module pat_key_ctrl #(
  parameter int unsigned CNT1US  = 107,
  parameter int unsigned CNT1MS  = 1000,
  parameter int unsigned PAT_NUM = 16,
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned AUTO_MS = 2000,
  parameter int unsigned LOCK_MS = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             key_next_n,
  input  logic             key_prev_n,
  input  logic             key_pause_n,
  output logic [PAT_W-1:0] pat_idx,
  output logic             pat_chg,
  output logic             auto_mode
);

  localparam int unsigned US_W  = (CNT1US > 1) ? $clog2(CNT1US) : 1;
  localparam int unsigned MS_W  = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [US_W-1:0]  US_LAST  = US_W'(CNT1US - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CNT1MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(AUTO_MS - 1);
  localparam logic [CNT_W-1:0] LOCK_LEN = CNT_W'(LOCK_MS);
  localparam logic [PAT_W-1:0] IDX_LAST = PAT_W'(PAT_NUM - 1);
  localparam logic             LOCK_OFF = (LOCK_MS == 0);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [US_W-1:0]  us_q, us_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic             lock_act_q, lock_act_d;
  logic [PAT_W-1:0] pat_idx_q, pat_idx_d;
  logic             pat_chg_q, pat_chg_d;

  logic us_tick, ms_tick, lock_ok;
  logic acc_pause, acc_next, acc_prev;
  logic dwell_exp, auto_adv, evt;

  // Timebase ticks; counters freeze while en is low.
  assign us_tick = en && (us_q == US_LAST);
  assign ms_tick = us_tick && (ms_q == MS_LAST);

  // Lockout only applies once an event has happened since reset.
  assign lock_ok = LOCK_OFF || !lock_act_q || (lock_q >= LOCK_LEN);

  // Key priority pause > next > prev; losers are dropped.
  assign acc_pause = en && lock_ok && !key_pause_n;
  assign acc_next  = en && lock_ok && key_pause_n && !key_next_n;
  assign acc_prev  = en && lock_ok && key_pause_n && key_next_n && !key_prev_n;

  // An accepted key in the expiry cycle wins over the auto advance.
  assign dwell_exp = (state_q == ST_AUTO) && ms_tick && (dwell_q == DWELL_LAST);
  assign auto_adv  = dwell_exp && !acc_pause && !acc_next && !acc_prev;
  assign evt       = acc_pause || acc_next || acc_prev || auto_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MANUAL: if (acc_pause) state_d = ST_AUTO;
      ST_AUTO:   if (acc_pause) state_d = ST_MANUAL;
    endcase
  end

  // Counter and pattern-index next values.
  always_comb begin
    us_d       = us_q;
    ms_d       = ms_q;
    dwell_d    = dwell_q;
    lock_d     = lock_q;
    lock_act_d = lock_act_q;
    pat_idx_d  = pat_idx_q;
    pat_chg_d  = 1'b0;

    if (evt) begin
      us_d       = '0;
      ms_d       = '0;
      dwell_d    = '0;
      lock_d     = '0;
      lock_act_d = 1'b1;
    end else if (en) begin
      us_d = us_tick ? '0 : us_q + US_W'(1);
      if (us_tick) begin
        ms_d = ms_tick ? '0 : ms_q + MS_W'(1);
      end
      if (state_q == ST_AUTO) begin
        if (ms_tick && (dwell_q != CNT_MAX)) dwell_d = dwell_q + CNT_W'(1);
      end else begin
        dwell_d = '0;
      end
      if (ms_tick && (lock_q != CNT_MAX)) lock_d = lock_q + CNT_W'(1);
    end

    if (acc_next || auto_adv) begin
      pat_idx_d = (pat_idx_q == IDX_LAST) ? '0 : pat_idx_q + PAT_W'(1);
      pat_chg_d = 1'b1;
    end else if (acc_prev) begin
      pat_idx_d = (pat_idx_q == '0) ? IDX_LAST : pat_idx_q - PAT_W'(1);
      pat_chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      us_q       <= '0;
      ms_q       <= '0;
      dwell_q    <= '0;
      lock_q     <= '0;
      lock_act_q <= 1'b0;
      pat_idx_q  <= '0;
      pat_chg_q  <= 1'b0;
    end else begin
      us_q       <= us_d;
      ms_q       <= ms_d;
      dwell_q    <= dwell_d;
      lock_q     <= lock_d;
      lock_act_q <= lock_act_d;
      pat_idx_q  <= pat_idx_d;
      pat_chg_q  <= pat_chg_d;
    end
  end

  assign pat_idx   = pat_idx_q;
  assign pat_chg   = pat_chg_q;
  assign auto_mode = (state_q == ST_AUTO);

endmodule

// File: tb/tb_pat_key_ctrl.sv
// Bench for pat_key_ctrl: directed scenarios plus random keys, checked every
// cycle against a clock-counting reference model through an expectation queue.
module tb_pat_key_ctrl;

  localparam int unsigned CNT1US  = 2;
  localparam int unsigned CNT1MS  = 5;
  localparam int unsigned PAT_NUM = 4;
  localparam int unsigned PAT_W   = 2;
  localparam int unsigned AUTO_MS = 4;
  localparam int unsigned LOCK_MS = 2;
  localparam int unsigned T_MS    = CNT1US * CNT1MS;
  localparam int unsigned DWELL   = AUTO_MS * T_MS;
  localparam int unsigned LOCKT   = LOCK_MS * T_MS;

  typedef struct packed {
    logic [PAT_W-1:0] idx;
    logic             chg;
    logic             am;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             key_next_n;
  logic             key_prev_n;
  logic             key_pause_n;
  logic [PAT_W-1:0] pat_idx;
  logic             pat_chg;
  logic             auto_mode;

  pat_key_ctrl #(
    .CNT1US (CNT1US),
    .CNT1MS (CNT1MS),
    .PAT_NUM(PAT_NUM),
    .PAT_W  (PAT_W),
    .AUTO_MS(AUTO_MS),
    .LOCK_MS(LOCK_MS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .key_pause_n(key_pause_n),
    .pat_idx    (pat_idx),
    .pat_chg    (pat_chg),
    .auto_mode  (auto_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;

  // Reference model: time is counted in enabled clocks since the last event.
  int m_idx   = 0;
  bit m_auto  = 1'b0;
  bit m_chg   = 1'b0;
  bit m_ever  = 1'b0;
  int m_since = 0;

  task automatic step(input bit r, input bit e, input bit kn, input bit kp, input bit kpa);
    bit lock_ok;
    bit ev;
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; key_next_n = kn; key_prev_n = kp; key_pause_n = kpa;
    if (!r) begin
      m_idx = 0; m_auto = 0; m_chg = 0; m_ever = 0; m_since = 0;
    end else if (!e) begin
      m_chg = 0;
    end else begin
      lock_ok = (LOCK_MS == 0) || !m_ever || (m_since >= int'(LOCKT));
      ev = 0;
      m_chg = 0;
      if (lock_ok && !kpa) begin
        m_auto = !m_auto; ev = 1;
      end else if (lock_ok && !kn) begin
        m_idx = (m_idx + 1) % PAT_NUM; m_chg = 1; ev = 1;
      end else if (lock_ok && !kp) begin
        m_idx = (m_idx + PAT_NUM - 1) % PAT_NUM; m_chg = 1; ev = 1;
      end else if (m_auto && (m_since + 1 == int'(DWELL))) begin
        m_idx = (m_idx + 1) % PAT_NUM; m_chg = 1; ev = 1;
      end
      if (ev) begin
        m_since = 0; m_ever = 1;
      end else begin
        m_since++;
      end
    end
    x.idx = PAT_W'(m_idx);
    x.chg = m_chg;
    x.am  = m_auto;
    exp_q.push_back(x);
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 1, 1, 1, 1);
  endtask

  task automatic do_reset();
    repeat (2) step(0, 1, 1, 1, 1);
  endtask

  // Advance until the next cycle is a dwell expiry in auto mode.
  task automatic wait_expiry(input int limit);
    int n = 0;
    while (!(m_auto && (m_since == int'(DWELL) - 1)) && n < limit) begin
      idle(1);
      n++;
    end
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL wait_expiry: budget %0d spent, since=%0d auto=%0d", limit, m_since, m_auto);
    end
  endtask

  task automatic wait_idx(input int target, input int limit);
    int n = 0;
    while (m_idx != target && n < limit) begin
      idle(1);
      n++;
    end
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL wait_idx: model idx=%0d required %0d within %0d", m_idx, target, limit);
    end
  endtask

  // Monitor: compare every output cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL exp_queue: empty at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (pat_idx !== e.idx || pat_chg !== e.chg || auto_mode !== e.am) begin
            bad++;
            $display("FAIL outputs t=%0t: got idx=%0d chg=%0b auto=%0b, want idx=%0d chg=%0b auto=%0b",
                     $time, pat_idx, pat_chg, auto_mode, e.idx, e.chg, e.am);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1;
    key_next_n = 1'b1; key_prev_n = 1'b1; key_pause_n = 1'b1;

    // Manual stepping with wrap in both directions.
    do_reset();
    idle(8);  step(1, 1, 0, 1, 1);
    idle(29); step(1, 1, 1, 0, 1);
    idle(29); step(1, 1, 1, 0, 1);
    idle(29); step(1, 1, 0, 1, 1);
    idle(25);

    // Lockout window.
    do_reset();
    idle(8);  step(1, 1, 0, 1, 1);
    idle(14); step(1, 1, 0, 1, 1);
    idle(5);  step(1, 1, 0, 1, 1);
    idle(4);  step(1, 1, 0, 1, 1);
    idle(25);

    // Auto run through a full wrap.
    do_reset();
    idle(8);  step(1, 1, 1, 1, 0);
    idle(170);
    step(1, 1, 1, 1, 0);
    idle(25);

    // Simultaneous keys.
    do_reset();
    idle(3); step(1, 1, 0, 0, 0);
    idle(25); step(1, 1, 0, 0, 1);
    idle(25); step(1, 1, 0, 0, 0);
    idle(25);

    // Collisions with dwell expiry in auto mode.
    do_reset();
    idle(3); step(1, 1, 1, 1, 0);
    wait_expiry(100); step(1, 1, 0, 1, 1);
    idle(45);
    wait_expiry(100); step(1, 1, 1, 0, 1);
    wait_expiry(100); step(1, 1, 1, 1, 0);
    idle(60);

    // Reset while in auto mode.
    do_reset();
    idle(3); step(1, 1, 1, 1, 0);
    wait_idx(2, 200);
    idle(3); step(0, 1, 1, 1, 1);
    idle(10);

    // en low for 15 cycles during auto, with a key pressed while disabled.
    do_reset();
    idle(3); step(1, 1, 1, 1, 0);
    idle(20);
    repeat (7) step(1, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1);
    repeat (7) step(1, 0, 1, 1, 1);
    idle(60);

    // Random keys, enable drops and occasional resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 499) != 0, $urandom_range(0, 15) != 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 29) != 0);
    end
    idle(3);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
